// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver, LSB first, CLKS_PER_BIT clocks per bit, SYNC_STAGES input flops.
// Optional: define UART_RX_STOP_CHECK_EN to drop frames whose stop bit samples low.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       receive_ack,
  output logic [7:0] data_i,
  output logic       LED
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE,
    WAIT_HIGH
  } state_t;

  localparam int          HALF      = CLKS_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = (HALF > 0) ? 16'(HALF - 1) : 16'd0;
  localparam bit          ONE_CLK   = (CLKS_PER_BIT == 1);

  logic        rxd_s;
  state_t      state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign rxd_s = rxd;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync;
    always_ff @(posedge clk) begin
      if (!rst) begin
        sync <= '1;
      end else begin
        sync[0] <= rxd;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      end
    end
    assign rxd_s = sync[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_i      <= '0;
      receive_ack <= 1'b0;
      LED         <= 1'b0;
    end else begin
      receive_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            // With one clock per bit the detecting edge already is the start-bit sample.
            state   <= ONE_CLK ? DATA : START;
          end
        end
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            state   <= rxd_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rxd_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
`ifdef UART_RX_STOP_CHECK_EN
            state   <= rxd_s ? DONE : WAIT_HIGH;
`else
            state   <= DONE;
`endif
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        DONE: begin
          data_i      <= shift;
          receive_ack <= 1'b1;
          LED         <= ~LED;
          state       <= IDLE;
        end
        WAIT_HIGH: begin
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: one-clock-per-bit and 16-clock-per-bit instances.
module tb_uart_byte_rx;

`ifdef UART_RX_STOP_CHECK_EN
  localparam bit STOP_CHECK = 1'b1;
`else
  localparam bit STOP_CHECK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd1 = 1'b1, rxd2 = 1'b1;
  logic       ack1, ack2, led1, led2;
  logic [7:0] data1, data2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] q1[$];
  logic [8:0] q2[$];
  logic       exp_led1 = 1'b0, exp_led2 = 1'b0;
  logic [7:0] last1 = 8'h00;
  logic       prev1 = 1'b0, prev2 = 1'b0;

  always #5 clk = ~clk;

  uart_byte_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(0)) dut1 (
    .clk(clk), .rst(rst), .rxd(rxd1),
    .receive_ack(ack1), .data_i(data1), .LED(led1)
  );

  uart_byte_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .rxd(rxd2),
    .receive_ack(ack2), .data_i(data2), .LED(led2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_bit(input int which, input logic v);
    if (which == 1) begin
      rxd1 = v;
      @(negedge clk);
    end else begin
      rxd2 = v;
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic idle_bits(input int which, input int n);
    for (int i = 0; i < n; i++) send_bit(which, 1'b1);
  endtask

  // Pushes the expected {LED, data} when the frame should be accepted.
  task automatic send_frame(input int which, input logic [7:0] b, input logic stop);
    if (stop || !STOP_CHECK) begin
      if (which == 1) begin
        exp_led1 = ~exp_led1;
        last1    = b;
        q1.push_back({exp_led1, b});
      end else begin
        exp_led2 = ~exp_led2;
        q2.push_back({exp_led2, b});
      end
    end
    send_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(which, b[i]);
    send_bit(which, stop);
    idle_bits(which, 5);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (ack1) begin
        if (prev1) begin
          n_checks++;
          $display("FAIL dut1_ack_width: ack high two cycles, expected one");
        end else if (q1.size() == 0) begin
          n_checks++;
          $display("FAIL dut1_unexpected_ack: data %0h, expected no ack", data1);
        end else begin
          chk("dut1_byte", {23'd0, led1, data1}, {23'd0, q1.pop_front()});
        end
      end
      if (ack2) begin
        if (prev2) begin
          n_checks++;
          $display("FAIL dut2_ack_width: ack high two cycles, expected one");
        end else if (q2.size() == 0) begin
          n_checks++;
          $display("FAIL dut2_unexpected_ack: data %0h, expected no ack", data2);
        end else begin
          chk("dut2_byte", {23'd0, led2, data2}, {23'd0, q2.pop_front()});
        end
      end
    end
    prev1 = ack1;
    prev2 = ack2;
  end

  initial begin
    // Reset held low with the line low.
    rxd1 = 1'b0;
    rxd2 = 1'b0;
    rst  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data1", {24'd0, data1}, 32'h00);
    chk("rst_ack1",  {31'd0, ack1},  32'h0);
    chk("rst_led1",  {31'd0, led1},  32'h0);
    chk("rst_data2", {24'd0, data2}, 32'h00);
    chk("rst_ack2",  {31'd0, ack2},  32'h0);
    chk("rst_led2",  {31'd0, led2},  32'h0);
    rxd1 = 1'b1;
    rxd2 = 1'b1;
    rst  = 1'b1;
    repeat (20) @(negedge clk);

    // Frame 0,0,1,1,1,0,0,1,0,0 -> 4E (stop bit low).
    send_frame(1, 8'h4E, 1'b0);
    chk("dut1_hold_after_stop0", {24'd0, data1}, {24'd0, last1});
    send_frame(1, 8'h4E, 1'b1);

    // Back-to-back frames with low stop bits.
    send_frame(1, 8'hFF, 1'b0);
    send_frame(1, 8'hCC, 1'b0);
    send_frame(1, 8'h11, 1'b0);
    idle_bits(1, 5);

    // Slow instance: A5, a 3-cycle glitch, then 5A to show it is back in IDLE.
    send_frame(2, 8'hA5, 1'b1);
    rxd2 = 1'b0;
    repeat (3) @(negedge clk);
    rxd2 = 1'b1;
    repeat (60) @(negedge clk);
    send_frame(2, 8'h5A, 1'b1);

    // Reset during bit 4 of a frame on the fast instance.
    send_bit(1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1, i[0]);
    rxd1 = 1'b1;
    rst  = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_data1", {24'd0, data1}, 32'h00);
    chk("midrst_led1",  {31'd0, led1},  32'h0);
    chk("midrst_data2", {24'd0, data2}, 32'h00);
    chk("midrst_led2",  {31'd0, led2},  32'h0);
    exp_led1 = 1'b0;
    exp_led2 = 1'b0;
    last1    = 8'h00;
    rst      = 1'b1;
    idle_bits(1, 5);
    send_frame(1, 8'h3C, 1'b1);

    for (int i = 0; i < 200 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    chk("dut1_pending", q1.size(), 32'd0);
    chk("dut2_pending", q2.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
